// File: rtl/hart_port_arbiter.sv
// hart_port_arbiter: request-aware round-robin owner of the shared memory/MMU port with quantum and hand-over gap.
// Define ARB_STATS_EN to add the per-hart r_grant_cnt grant counters.
module hart_port_arbiter #(
    parameter int N_HARTS    = 2,
    parameter int QUANTUM    = 4,
    parameter int SWITCH_GAP = 1,
    localparam int SELW      = (N_HARTS > 1) ? $clog2(N_HARTS) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N_HARTS-1:0] w_req,
    input  logic [N_HARTS-1:0] w_safe,
    input  logic               w_hold,
    input  logic               w_busy,
    output logic [SELW-1:0]    r_sel,
    output logic [N_HARTS-1:0] w_grant,
    output logic [N_HARTS-1:0] w_core_busy,
    output logic               r_switch
`ifdef ARB_STATS_EN
    ,
    output logic [32*N_HARTS-1:0] r_grant_cnt
`endif
);
    localparam int QW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
    localparam logic [QW-1:0] QMAX = QW'(QUANTUM - 1);

    typedef enum logic {OWN, GAP} state_e;

    state_e          state_q, state_d;
    logic [SELW-1:0] sel_q, sel_d, nxt_q, nxt_d, cand;
    logic [QW-1:0]   q_q, q_d;
    logic [3:0]      gap_q, gap_d;
    logic            switch_q, switch_d;
    logic            has_cand, qc, commit;

    // Descending scan so the nearest requester after the owner wins.
    always_comb begin
        logic [SELW-1:0] idx;
        idx      = '0;
        cand     = '0;
        has_cand = 1'b0;
        for (int i = N_HARTS - 1; i >= 1; i--) begin
            idx = SELW'((int'(sel_q) + i) % N_HARTS);
            if (w_req[idx]) begin
                cand     = idx;
                has_cand = 1'b1;
            end
        end
    end

    assign qc     = (state_q == OWN) && w_safe[sel_q] && !w_hold && !w_busy;
    assign commit = qc && has_cand && ((q_q == QMAX) || !w_req[sel_q]);

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        nxt_d    = nxt_q;
        q_d      = q_q;
        gap_d    = gap_q;
        switch_d = 1'b0;
        if (state_q == OWN) begin
            if (commit) begin
                nxt_d = cand;
                q_d   = '0;
                if (SWITCH_GAP == 0) begin
                    sel_d    = cand;
                    switch_d = 1'b1;
                end else begin
                    state_d = GAP;
                    gap_d   = 4'(SWITCH_GAP - 1);
                end
            end else if (qc) begin
                q_d = (q_q == QMAX) ? q_q : q_q + 1'b1;
            end
        end else if (gap_q == 4'd0) begin
            state_d  = OWN;
            sel_d    = nxt_q;
            switch_d = 1'b1;
        end else begin
            gap_d = gap_q - 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= OWN;
            sel_q    <= '0;
            nxt_q    <= '0;
            q_q      <= '0;
            gap_q    <= '0;
            switch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            nxt_q    <= nxt_d;
            q_q      <= q_d;
            gap_q    <= gap_d;
            switch_q <= switch_d;
        end
    end

    always_comb begin
        w_grant     = '0;
        w_core_busy = '1;
        if (state_q == OWN) begin
            w_grant[sel_q]     = 1'b1;
            w_core_busy[sel_q] = w_busy;
        end
    end

    assign r_sel    = sel_q;
    assign r_switch = switch_q;

`ifdef ARB_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST)
            r_grant_cnt <= '0;
        else if (switch_q)
            r_grant_cnt[32*sel_q +: 32] <= r_grant_cnt[32*sel_q +: 32] + 32'd1;
    end
`endif
endmodule

// File: tb/tb_hart_port_arbiter.sv
// tb_hart_port_arbiter: directed checks of several arbiter configurations sharing one clock and reset.
module tb_hart_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold = 1'b0;
    logic busy = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic [1:0] a_req = '0, a_safe = '0, a_gnt, a_cb;
    logic       a_sel, a_sw;
    logic [3:0] b_req = '0, b_safe = '0, b_gnt, b_cb;
    logic [1:0] b_sel;
    logic       b_sw;
    logic [1:0] c_req = '0, c_safe = '0, c_gnt, c_cb;
    logic       c_sel, c_sw;
    logic [3:0] d_req = '0, d_safe = '0, d_gnt, d_cb;
    logic [1:0] d_sel;
    logic       d_sw;
    logic [1:0] e_req = '0, e_safe = '0, e_gnt, e_cb;
    logic       e_sel, e_sw;
    logic [0:0] f_req = '0, f_safe = '0, f_gnt, f_cb;
    logic       f_sel, f_sw;
`ifdef ARB_STATS_EN
    logic [63:0]  a_cnt, c_cnt, e_cnt;
    logic [127:0] b_cnt, d_cnt;
    logic [31:0]  f_cnt;
`endif

    hart_port_arbiter #(.N_HARTS(2), .QUANTUM(1), .SWITCH_GAP(1)) dut_a (
        .CLK(clk), .RST(rst), .w_req(a_req), .w_safe(a_safe), .w_hold(hold), .w_busy(busy),
        .r_sel(a_sel), .w_grant(a_gnt), .w_core_busy(a_cb), .r_switch(a_sw)
`ifdef ARB_STATS_EN
        , .r_grant_cnt(a_cnt)
`endif
    );
    hart_port_arbiter #(.N_HARTS(4), .QUANTUM(4), .SWITCH_GAP(1)) dut_b (
        .CLK(clk), .RST(rst), .w_req(b_req), .w_safe(b_safe), .w_hold(hold), .w_busy(busy),
        .r_sel(b_sel), .w_grant(b_gnt), .w_core_busy(b_cb), .r_switch(b_sw)
`ifdef ARB_STATS_EN
        , .r_grant_cnt(b_cnt)
`endif
    );
    hart_port_arbiter #(.N_HARTS(2), .QUANTUM(4), .SWITCH_GAP(0)) dut_c (
        .CLK(clk), .RST(rst), .w_req(c_req), .w_safe(c_safe), .w_hold(hold), .w_busy(busy),
        .r_sel(c_sel), .w_grant(c_gnt), .w_core_busy(c_cb), .r_switch(c_sw)
`ifdef ARB_STATS_EN
        , .r_grant_cnt(c_cnt)
`endif
    );
    hart_port_arbiter #(.N_HARTS(4), .QUANTUM(1), .SWITCH_GAP(3)) dut_d (
        .CLK(clk), .RST(rst), .w_req(d_req), .w_safe(d_safe), .w_hold(hold), .w_busy(busy),
        .r_sel(d_sel), .w_grant(d_gnt), .w_core_busy(d_cb), .r_switch(d_sw)
`ifdef ARB_STATS_EN
        , .r_grant_cnt(d_cnt)
`endif
    );
    hart_port_arbiter #(.N_HARTS(2), .QUANTUM(1), .SWITCH_GAP(0)) dut_e (
        .CLK(clk), .RST(rst), .w_req(e_req), .w_safe(e_safe), .w_hold(hold), .w_busy(busy),
        .r_sel(e_sel), .w_grant(e_gnt), .w_core_busy(e_cb), .r_switch(e_sw)
`ifdef ARB_STATS_EN
        , .r_grant_cnt(e_cnt)
`endif
    );
    hart_port_arbiter #(.N_HARTS(1), .QUANTUM(1), .SWITCH_GAP(0)) dut_f (
        .CLK(clk), .RST(rst), .w_req(f_req), .w_safe(f_safe), .w_hold(hold), .w_busy(busy),
        .r_sel(f_sel), .w_grant(f_gnt), .w_core_busy(f_cb), .r_switch(f_sw)
`ifdef ARB_STATS_EN
        , .r_grant_cnt(f_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // dut_b expectations after edges 1..15 (sel holds the outgoing owner during the gap)
    logic [1:0] b_exp_sel [15] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 3, 3, 3, 3, 3, 0};
    logic [3:0] b_exp_gnt [15] = '{1, 1, 1, 0, 2, 2, 2, 2, 0, 8, 8, 8, 8, 0, 1};
    logic       b_exp_sw  [15] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        do_reset();
        check("rst_sel", a_sel, 0);
        check("rst_gnt", a_gnt, 2'b01);
        check("rst_sw", a_sw, 0);
        check("rst_cb", a_cb, 2'b10);
        check("rst_b_gnt", b_gnt, 4'b0001);
`ifdef ARB_STATS_EN
        check("rst_cnt", a_cnt, 0);
`endif
        // Test 1: Q=1, GAP=1 alternation with period 4; also N=1 never switches
        a_req = 2'b11; a_safe = 2'b11;
        f_req = 1'b1; f_safe = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k % 2 == 1) begin
                check("t1_gap_gnt", a_gnt, 2'b00);
                check("t1_gap_cb", a_cb, 2'b11);
                check("t1_gap_sw", a_sw, 0);
            end else begin
                check("t1_sel", a_sel, (k / 2) % 2);
                check("t1_gnt", a_gnt, ((k / 2) % 2) ? 2'b10 : 2'b01);
                check("t1_sw", a_sw, 1);
            end
            check("n1_sw", f_sw, 0);
            check("n1_gnt", f_gnt, 1'b1);
        end
        check("n1_sel", f_sel, 0);

        // Test 2: N=4, Q=4, req=1011 -> 0, 1, 3 (skipping 2), 0
        do_reset();
        b_req = 4'b1011; b_safe = 4'b1111;
        for (int k = 0; k < 15; k++) begin
            tick();
            check("t2_sel", b_sel, b_exp_sel[k]);
            check("t2_gnt", b_gnt, b_exp_gnt[k]);
            check("t2_sw", b_sw, b_exp_sw[k]);
        end

        // Test 3: hold then busy block the quantum-expiry switch
        do_reset();
        c_req = 2'b11; c_safe = 2'b11;
        tick(); tick(); tick();
        check("t3_q3_sel", c_sel, 0);
        hold = 1'b1;
        tick();
        check("t3_hold_sel", c_sel, 0);
        check("t3_hold_sw", c_sw, 0);
        hold = 1'b0; busy = 1'b1;
        #1;
        check("t3_busy_cb", c_cb, 2'b11);
        tick();
        check("t3_busy_sel", c_sel, 0);
        busy = 1'b0;
        tick();
        check("t3_sel", c_sel, 1);
        check("t3_sw", c_sw, 1);
        check("t3_gnt", c_gnt, 2'b10);
        check("t3_cb", c_cb, 2'b01);

        // Test 4: idle owner yields at its next QC without waiting for the quantum
        do_reset();
        c_req = 2'b10; c_safe = 2'b00;
        tick();
        check("t4_nosafe_sel", c_sel, 0);
        c_safe = 2'b01;
        tick();
        check("t4_sel", c_sel, 1);
        check("t4_sw", c_sw, 1);
        c_req = 2'b00; c_safe = 2'b11;
        tick(); tick();
        check("t4_keep_sel", c_sel, 1);
        check("t4_keep_sw", c_sw, 0);

        // Test 5: reset in the 2nd gap cycle, then a full gap with a dropped target
        do_reset();
        d_req = 4'b0011; d_safe = 4'b1111;
        tick();
        check("t5_gap1_gnt", d_gnt, 4'b0000);
        tick();
        check("t5_gap2_gnt", d_gnt, 4'b0000);
        rst = 1'b1;
        tick();
        check("t5_rst_sel", d_sel, 0);
        check("t5_rst_gnt", d_gnt, 4'b0001);
        check("t5_rst_sw", d_sw, 0);
        rst = 1'b0;
        tick();
        check("t5_g1", d_gnt, 4'b0000);
        d_req = 4'b0001;
        tick();
        check("t5_g2", d_gnt, 4'b0000);
        tick();
        check("t5_g3", d_gnt, 4'b0000);
        check("t5_g3_sw", d_sw, 0);
        tick();
        check("t5_sel", d_sel, 1);
        check("t5_gnt", d_gnt, 4'b0010);
        check("t5_sw", d_sw, 1);

        // Test 6: Q=1, GAP=0 switches every cycle; 10 switches then stop
        do_reset();
        e_req = 2'b11; e_safe = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("t6_sel", e_sel, k % 2);
            check("t6_sw", e_sw, 1);
            check("t6_cb", e_cb, (k % 2) ? 2'b01 : 2'b10);
        end
        e_req = 2'b00;
        tick();
        check("t6_stop_sw", e_sw, 0);
        tick();
`ifdef ARB_STATS_EN
        check("t6_cnt", e_cnt, {32'd5, 32'd5});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
